// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register-file write arbiter.
package regfile_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_e;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared on RF commit.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_valid_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic              clr_valid_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    output logic              rs1_busy_o,
    output logic              rs2_busy_o
);
    localparam int NREGS = 1 << ADDR_W;

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_d[gi] = 1'b0;
            end else begin : g_reg
                logic set_hit;
                logic clr_hit;
                assign set_hit = set_valid_i && (set_addr_i == ADDR_W'(gi));
                assign clr_hit = clr_valid_i && (clr_addr_i == ADDR_W'(gi));
                // A same-edge set belongs to a newer instruction, so it beats the clear.
                assign busy_d[gi] = set_hit || (busy_q[gi] && !clr_hit);
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs1_busy_o = busy_q[rs1_addr_i];
    assign rs2_busy_o = busy_q[rs2_addr_i];
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between writeback requesters, zero-sweeps
// x1..x31 after reset, and tracks pending writes for RAW stall checks.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DATA_W  = REG_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      issue_valid,
    input  logic [ADDR_W-1:0]         issue_rd,
    output logic                      issue_ready,
    input  logic [ADDR_W-1:0]         rs1_addr,
    input  logic [ADDR_W-1:0]         rs2_addr,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic                      rf_write_enable,
    output logic [ADDR_W-1:0]         rf_write_reg,
    output logic [DATA_W-1:0]         rf_write_data,
    output logic                      init_done
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = ADDR_W + 1;

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  rr_q, rr_d;
    logic              init_done_q, init_done_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [ADDR_W-1:0] addr_a [NUM_REQ];
    logic [DATA_W-1:0] data_a [NUM_REQ];
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]  win_idx;
    logic              contested;
    int                nv;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign addr_a[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            assign data_a[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Scan from the pointer downward so the valid requester closest to it wins.
    always_comb begin
        win_idx = '0;
        nv      = 0;
        grant   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_q) + k) % NUM_REQ]) begin
                win_idx = PTR_W'((int'(rr_q) + k) % NUM_REQ);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            nv = nv + int'(req_valid[i]);
        end
        if (state_q == RUN && |req_valid) begin
            grant[win_idx] = 1'b1;
        end
    end

    assign contested = (nv > 1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        init_done_d = init_done_q;
        we_d        = 1'b0;
        wreg_d      = wreg_q;
        wdata_d     = wdata_q;
        if (state_q == INIT) begin
            // Counter top bit set means every nonzero register has been swept.
            if (cnt_q[CNT_W-1]) begin
                state_d     = RUN;
                init_done_d = 1'b1;
            end else begin
                we_d    = 1'b1;
                wreg_d  = cnt_q[ADDR_W-1:0];
                wdata_d = '0;
                cnt_d   = cnt_q + 1'b1;
            end
        end else if (|grant) begin
            we_d    = (addr_a[win_idx] != REG_ZERO);
            wreg_d  = addr_a[win_idx];
            wdata_d = data_a[win_idx];
            if (contested) begin
                rr_d = PTR_W'((int'(win_idx) + 1) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT;
            cnt_q       <= CNT_W'(1);
            rr_q        <= '0;
            init_done_q <= 1'b0;
            we_q        <= 1'b0;
            wreg_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            init_done_q <= init_done_d;
            we_q        <= we_d;
            wreg_q      <= wreg_d;
            wdata_q     <= wdata_d;
        end
    end

    reg_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .set_valid_i (issue_valid && init_done_q),
        .set_addr_i  (issue_rd),
        .clr_valid_i (we_q),
        .clr_addr_i  (wreg_q),
        .rs1_addr_i  (rs1_addr),
        .rs2_addr_i  (rs2_addr),
        .rs1_busy_o  (rs1_busy),
        .rs2_busy_o  (rs2_busy)
    );

    assign req_ready       = grant;
    assign issue_ready     = init_done_q;
    assign init_done       = init_done_q;
    assign rf_write_enable = we_q;
    assign rf_write_reg    = wreg_q;
    assign rf_write_data   = wdata_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: behavioural model + per-cycle compare, directed vectors.
module tb_regfile_write_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [9:0]  req_addr = '0;
    logic [63:0] req_data = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_ready;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic        rs1_busy, rs2_busy;
    logic        rf_write_enable;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic        init_done;

    int n_vec = 0;
    int n_err = 0;

    regfile_write_arbiter #(.NUM_REQ(2), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_write_enable(rf_write_enable), .rf_write_reg(rf_write_reg),
        .rf_write_data(rf_write_data), .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Register file attached to the write port (commits one edge after the outputs load).
    logic [31:0] rf_mem [32] = '{default: '0};
    logic [31:0] rf_wr = '0;
    always @(posedge clk) begin
        if (rf_write_enable) begin
            rf_mem[rf_write_reg] <= rf_write_data;
            rf_wr[rf_write_reg]  <= 1'b1;
        end
    end

    // Behavioural model: edges since reset release, pending-write set, expected output word.
    int          m_edges;
    logic        m_done, m_we, m_ptr;
    logic [4:0]  m_reg;
    logic [31:0] m_data, m_busy;

    function automatic logic [1:0] exp_ready();
        if (!m_done || req_valid == 2'b00) return 2'b00;
        if (req_valid == 2'b11) return m_ptr ? 2'b10 : 2'b01;
        return req_valid;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic [1:0]  g;
        logic [31:0] nb;
        int          w;
        if (rst) begin
            m_edges <= 0; m_done <= 1'b0; m_we <= 1'b0; m_ptr <= 1'b0;
            m_reg <= '0; m_data <= '0; m_busy <= '0;
        end else if (!m_done) begin
            m_edges <= m_edges + 1;
            if (m_edges + 1 <= 31) begin
                m_we <= 1'b1; m_reg <= 5'(m_edges + 1); m_data <= '0;
            end else begin
                m_we <= 1'b0; m_done <= 1'b1;
            end
        end else begin
            g  = exp_ready();
            nb = m_busy;
            if (m_we) nb[m_reg] = 1'b0;
            if (issue_valid && issue_rd != 0) nb[issue_rd] = 1'b1;
            m_busy <= nb;
            if (g != 2'b00) begin
                w = g[1] ? 1 : 0;
                m_we   <= (req_addr[w*5 +: 5] != 5'd0);
                m_reg  <= req_addr[w*5 +: 5];
                m_data <= req_data[w*32 +: 32];
                if (req_valid == 2'b11) m_ptr <= ~m_ptr;
            end else begin
                m_we <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_outputs", {req_ready, issue_ready, rs1_busy, rs2_busy, rf_write_enable,
                                init_done, rf_write_reg}, '0);
            chk("rst_wdata", rf_write_data, '0);
        end else begin
            chk("we", rf_write_enable, m_we);
            if (m_we) begin
                chk("wreg", rf_write_reg, m_reg);
                chk("wdata", rf_write_data, m_data);
            end
            chk("init_done", init_done, m_done);
            chk("issue_ready", issue_ready, m_done);
            chk("req_ready", req_ready, exp_ready());
            chk("rs1_busy", rs1_busy, (rs1_addr != 0) && m_busy[rs1_addr]);
            chk("rs2_busy", rs2_busy, (rs2_addr != 0) && m_busy[rs2_addr]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Zero sweep after reset release
        repeat (3) tick();
        rst = 1'b0;
        repeat (31) tick();
        chk("sweep_last_we", rf_write_enable, 1);
        chk("sweep_last_reg", rf_write_reg, 31);
        chk("sweep_not_done", init_done, 0);
        tick();
        chk("sweep_done", init_done, 1);
        chk("sweep_we_off", rf_write_enable, 0);
        chk("x10_written", rf_wr[10], 1);
        chk("x10_zero", rf_mem[10], 32'h0);
        chk("x31_written", rf_wr[31], 1);

        // Single requester write
        req_valid = 2'b01; req_addr = {5'd0, 5'd1}; req_data = {32'h0, 32'hAABBCCDD};
        #1 chk("single_ready", req_ready, 2'b01);
        tick(); req_valid = 2'b00;
        chk("single_out", {rf_write_enable, 3'b0, rf_write_reg}, 9'h101);
        chk("single_data", rf_write_data, 32'hAABBCCDD);
        tick();
        chk("x1_commit", rf_mem[1], 32'hAABBCCDD);

        // Contention: grants alternate 0,1,0,1
        req_addr = {5'd5, 5'd3}; req_data = {32'hABCDEFFF, 32'h87654321}; req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("rr_grant%0d", k), req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
            tick();
        end
        req_valid = 2'b00;
        tick(); tick();
        chk("x3_commit", rf_mem[3], 32'h87654321);
        chk("x5_commit", rf_mem[5], 32'hABCDEFFF);

        // RAW scoreboard set/clear
        issue_valid = 1'b1; issue_rd = 5'd4; rs1_addr = 5'd4;
        tick(); issue_valid = 1'b0;
        chk("x4_busy_set", rs1_busy, 1);
        req_valid = 2'b10; req_addr = {5'd4, 5'd0}; req_data = {32'h12345678, 32'h0};
        #1 chk("x4_ready", req_ready, 2'b10);
        tick(); req_valid = 2'b00;
        chk("x4_busy_inflight", rs1_busy, 1);
        tick();
        chk("x4_busy_clear", rs1_busy, 0);
        chk("x4_data_at_clear", rf_mem[4], 32'h12345678);

        // Same-edge set and clear: set wins
        issue_valid = 1'b1; issue_rd = 5'd6; rs2_addr = 5'd6;
        tick(); issue_valid = 1'b0;
        req_valid = 2'b01; req_addr = {5'd0, 5'd6}; req_data = {32'h0, 32'h00000066};
        tick(); req_valid = 2'b00; issue_valid = 1'b1; issue_rd = 5'd6;
        tick(); issue_valid = 1'b0;
        chk("x6_set_wins", rs2_busy, 1);
        req_valid = 2'b01;
        tick(); req_valid = 2'b00;
        tick();
        chk("x6_cleared", rs2_busy, 0);

        // Write to x0
        req_valid = 2'b01; req_addr = {5'd0, 5'd0}; req_data = {32'h0, 32'hABCDEFFF};
        issue_valid = 1'b1; issue_rd = 5'd0; rs1_addr = 5'd0;
        #1 chk("x0_ready", req_ready, 2'b01);
        tick(); req_valid = 2'b00; issue_valid = 1'b0;
        chk("x0_we_off", rf_write_enable, 0);
        chk("x0_busy", rs1_busy, 0);
        tick();
        chk("x0_reads_zero", rf_mem[0], 32'h0);

        // Reset mid-sweep restarts from x1
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (15) tick();
        chk("mid_sweep_reg", {rf_write_enable, 3'b0, rf_write_reg}, 9'h10F);
        rst = 1'b1;
        #1 chk("async_rst_outs", {rf_write_enable, init_done, req_ready, issue_ready, rf_write_reg}, '0);
        tick(); rst = 1'b0;
        tick();
        chk("restart_reg", {rf_write_enable, 3'b0, rf_write_reg}, 9'h101);
        repeat (30) tick();
        chk("restart_not_done", init_done, 0);
        tick();
        chk("restart_done", init_done, 1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Sequences and shares the single write port of the 32x32 `register_file`, which has no reset, between NUM_REQ writeback requesters (req 0 = ALU, req 1 = load unit).
- After reset, sweeps x1..x31 to zero so no register reads X.
- Keeps a pending-write scoreboard so decode can stall on RAW hazards.
- Sits between the writeback stage and the `register_file` write inputs.

Parameters:
- NUM_REQ, 2, number of writeback requesters (round-robin arbitration).
- ADDR_W, 5, register index width.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  writeback request valid, one bit per requester.
- req_ready  out  NUM_REQ  grant/accept, one bit per requester.
- req_addr  in  NUM_REQ*ADDR_W  destination register; requester i uses slice [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  write data, sliced the same way.
- issue_valid  in  1  instruction issued with destination issue_rd.
- issue_rd  in  ADDR_W  destination register to mark pending.
- issue_ready  out  1  issue accepted; equals init_done.
- rs1_addr, rs2_addr  in  ADDR_W each  source registers to check.
- rs1_busy, rs2_busy  out  1 each  combinational: source has a pending write.
- rf_write_enable  out  1  to register_file write_enable.
- rf_write_reg  out  ADDR_W  to register_file write_reg.
- rf_write_data  out  DATA_W  to register_file write_data.
- init_done  out  1  zero-sweep complete; normal operation.

Behaviour:
- Reset (async, while rst=1):
  - rf_write_enable=0, rf_write_reg=0, rf_write_data=0.
  - init_done=0, req_ready=0, issue_ready=0.
  - All busy bits 0, round-robin pointer=0, state=INIT, sweep counter=1.
  - Reset mid-sweep or mid-operation restarts from INIT; in-flight requests are dropped.
- State INIT:
  - On rising edges 1..31 after rst falls, outputs load we=1, reg=counter, data=0; counter then increments.
  - On edge 32: we<=0, state<=RUN, init_done<=1.
  - req_ready=0 and issue_ready=0 throughout INIT.
- State RUN, arbitration:
  - req_ready is combinational. Exactly one requester is granted when any valid is high: the sole valid requester, or on contention the requester at the RR pointer.
  - The pointer advances to the other requester only after a contested grant.
  - Transfer = valid & ready at a rising edge. That edge loads rf_write_enable=1 with the winner's addr/data; the register_file commits on the following edge (2-edge write latency).
  - With no transfer, rf_write_enable<=0 and rf_write_reg/rf_write_data hold their values.
  - An unaccepted requester must hold valid/addr/data stable.
- Writes to x0:
  - Accepted (ready=1) but the output loads we=0.
  - Busy bit 0 is never set.
- Scoreboard, busy[31:1]:
  - Set: issue_valid & issue_ready & issue_rd!=0 sets busy[issue_rd] at the edge.
  - Clear: on an edge where rf_write_enable=1, busy[rf_write_reg] clears; this is the same edge the RF commits. A reader seeing busy=0 therefore reads committed data (RF read is asynchronous).
  - Set and clear to the same register on one edge: set wins (newer instruction pending).
  - rsN_busy = busy[rsN_addr]; always 0 for x0.
- Full throughput: one accepted write per cycle, sustained.

Decomposition:
- Shared package `regfile_pkg`: REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32, REG_ZERO=0, and state encoding {INIT, RUN}.
- One sub-module, `reg_scoreboard`: busy vector, set/clear logic with set priority, two combinational query ports.
- The arbiter, sweep FSM and output registers stay in the top module.

Test Plan:
- Reset release, no requests -> x1..x31 written with 0 on edges 1..31 (we=1), init_done=1 after edge 32; reading x10 afterwards returns 32'h00000000, not X.
- RUN: req0 valid, addr=1, data=AABBCCDD -> ready0=1 same cycle; rf outputs {1,1,AABBCCDD} next cycle; x1 reads AABBCCDD after the following edge.
- Both valid every cycle (req0 addr 3 data 87654321; req1 addr 5 data ABCDEFFF) -> grants alternate 0,1,0,1; no cycle has both readies high.
- issue rd=4 -> rs1_busy=1 for rs1_addr=4; req1 writes x4=12345678 -> busy clears on the RF commit edge, and x4 reads 12345678 in the same cycle busy first reads 0.
- Request addr=0 data=ABCDEFFF -> ready=1, rf_write_enable stays 0, x0 reads 0, rs1_busy for x0 = 0.
- Assert rst during sweep at counter 15 -> all outputs 0 immediately; after release the sweep restarts at x1 and init_done rises 32 edges later.
